axis_window_acc: RTL and testbench



---
 rtl/axis_window_acc_pkg.sv | 23 ++
 rtl/axis_window_obuf.sv | 45 ++++
 rtl/axis_window_acc.sv | 144 ++++++++++++++
 tb/tb_axis_window_acc.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_window_acc_pkg.sv
// Shared types and constants for the AXI4-Stream window accumulator.
// The result struct is sized for the widest supported build; narrower builds leave its upper bits at zero.
package axis_window_acc_pkg;

   localparam int DEF_TDATA_WIDTH = 128;
   localparam int DEF_FLAG_WIDTH  = 66;
   localparam int DEF_CNTR_WIDTH  = 8;
   localparam int DROP_CNTR_WIDTH = 16;
   localparam int RES_TDATA_MAX   = 1024;
   localparam int RES_TUSER_MAX   = 32;

   typedef enum logic {
      ST_IDLE,
      ST_OPEN
   } state_t;

   typedef struct packed {
      logic [RES_TDATA_MAX-1:0] tdata;
      logic [RES_TUSER_MAX-1:0] tuser;
      logic                     tlast;
   } result_t;

endpackage

// File: rtl/axis_window_obuf.sv
// One-entry output register slice: loads when empty or draining, otherwise drops the
// offered result and bumps a saturating drop counter. The held word never changes while stalled.
module axis_window_obuf
   import axis_window_acc_pkg::*;
(
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       load,
   input  result_t                    load_res,
   output result_t                    out_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DROP_CNTR_WIDTH-1:0] sts_drops
);

   logic                       full_reg;
   result_t                    res_reg;
   logic [DROP_CNTR_WIDTH-1:0] drops_reg;
   logic                       accept;

   assign accept = !full_reg || out_ready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         full_reg  <= 1'b0;
         res_reg   <= '0;
         drops_reg <= '0;
      end else begin
         if (load && accept) begin
            res_reg  <= load_res;
            full_reg <= 1'b1;
         end else if (full_reg && out_ready) begin
            full_reg <= 1'b0;
         end
         if (load && !accept && !(&drops_reg)) begin
            drops_reg <= drops_reg + 1'b1;
         end
      end
   end

   assign out_res   = res_reg;
   assign out_valid = full_reg;
   assign sts_drops = drops_reg;

endmodule

// File: rtl/axis_window_acc.sv
// Merges a burst of stream samples into one word per window of cfg_len cycles (0 = pass-through).
// Define AXIS_WINDOW_ACC_TLAST_EN to add s_axis_tlast/m_axis_tlast and early close on tlast.
module axis_window_acc
   import axis_window_acc_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
   parameter int FLAG_WIDTH       = DEF_FLAG_WIDTH,
   parameter int CNTR_WIDTH       = DEF_CNTR_WIDTH
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [CNTR_WIDTH-1:0]       cfg_len,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
`ifdef AXIS_WINDOW_ACC_TLAST_EN
   input  logic                        s_axis_tlast,
   output logic                        m_axis_tlast,
`endif
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [CNTR_WIDTH-1:0]       m_axis_tuser,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [DROP_CNTR_WIDTH-1:0]  sts_drops
);

   state_t                      state_reg, state_next;
   logic [AXIS_TDATA_WIDTH-1:0] acc_reg, acc_next, merged;
   logic [CNTR_WIDTH-1:0]       cntr_reg, cntr_next;
   logic [CNTR_WIDTH-1:0]       len_reg, len_next;
   logic [CNTR_WIDTH-1:0]       nsamp_reg, nsamp_next, nsamp_inc;
   logic [AXIS_TDATA_WIDTH-1:0] offer_tdata;
   logic [CNTR_WIDTH-1:0]       offer_tuser;
   logic                        offer_tlast;
   logic                        offer;
   logic                        tlast_in;
   result_t                     offer_res, out_res;
   logic                        unused_res;

`ifdef AXIS_WINDOW_ACC_TLAST_EN
   assign tlast_in = s_axis_tlast;
`else
   assign tlast_in = 1'b0;
`endif

   // Only the low FLAG_WIDTH bits accumulate; the rest keep the opening sample.
   genvar gi;
   generate
      for (gi = 0; gi < AXIS_TDATA_WIDTH; gi++) begin : g_merge
         if (gi < FLAG_WIDTH) begin : g_flag
            assign merged[gi] = acc_reg[gi] | (s_axis_tvalid & s_axis_tdata[gi]);
         end else begin : g_keep
            assign merged[gi] = acc_reg[gi];
         end
      end
   endgenerate

   assign nsamp_inc = (&nsamp_reg) ? nsamp_reg : nsamp_reg + 1'b1;

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      cntr_next   = cntr_reg;
      len_next    = len_reg;
      nsamp_next  = nsamp_reg;
      offer       = 1'b0;
      offer_tdata = s_axis_tdata;
      offer_tuser = CNTR_WIDTH'(1);
      offer_tlast = tlast_in;
      case (state_reg)
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               if (cfg_len == '0) begin
                  offer = 1'b1;
               end else begin
                  acc_next   = s_axis_tdata;
                  nsamp_next = CNTR_WIDTH'(1);
                  cntr_next  = CNTR_WIDTH'(1);
                  len_next   = cfg_len;
                  if (cfg_len == CNTR_WIDTH'(1) || tlast_in) begin
                     offer = 1'b1;
                  end else begin
                     state_next = ST_OPEN;
                  end
               end
            end
         end
         ST_OPEN: begin
            // cntr_next counts window cycles including this one, so a match is the last cycle.
            cntr_next = cntr_reg + 1'b1;
            acc_next  = merged;
            if (s_axis_tvalid) begin
               nsamp_next = nsamp_inc;
            end
            offer_tdata = merged;
            offer_tuser = nsamp_next;
            offer_tlast = s_axis_tvalid & tlast_in;
            if (cntr_next == len_reg || (s_axis_tvalid && tlast_in)) begin
               offer      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      offer_res = '0;
      offer_res.tdata[AXIS_TDATA_WIDTH-1:0] = offer_tdata;
      offer_res.tuser[CNTR_WIDTH-1:0]       = offer_tuser;
      offer_res.tlast                       = offer_tlast;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         cntr_reg  <= '0;
         len_reg   <= '0;
         nsamp_reg <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cntr_reg  <= cntr_next;
         len_reg   <= len_next;
         nsamp_reg <= nsamp_next;
      end
   end

   axis_window_obuf u_obuf (
      .aclk      (aclk),
      .areset    (areset),
      .load      (offer),
      .load_res  (offer_res),
      .out_res   (out_res),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .sts_drops (sts_drops)
   );

   assign m_axis_tdata = out_res.tdata[AXIS_TDATA_WIDTH-1:0];
   assign m_axis_tuser = out_res.tuser[CNTR_WIDTH-1:0];
`ifdef AXIS_WINDOW_ACC_TLAST_EN
   assign m_axis_tlast = out_res.tlast;
`endif
   assign unused_res = ^{out_res.tdata, out_res.tuser, out_res.tlast};

endmodule

// File: tb/tb_axis_window_acc.sv
// Randomised and directed bench for axis_window_acc against a window-level reference model.
// Stimulus per phase is tabulated first, then replayed; expected outputs are derived from the table.
module tb_axis_window_acc;

   localparam int W    = 128;
   localparam int FW   = 66;
   localparam int C    = 8;
   localparam int MAXC = 512;
   localparam logic [W-1:0] FLAG_MASK = {{(W-FW){1'b0}}, {FW{1'b1}}};

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [C-1:0]  cfg_len = '0;
   logic [W-1:0]  s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          m_tlast;
   logic [W-1:0]  m_axis_tdata;
   logic [C-1:0]  m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [15:0]   sts_drops;

   always #5 aclk = ~aclk;

   axis_window_acc dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_len       (cfg_len),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
`ifdef AXIS_WINDOW_ACC_TLAST_EN
      .s_axis_tlast  (s_tlast),
      .m_axis_tlast  (m_tlast),
`endif
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .sts_drops     (sts_drops)
   );
`ifndef AXIS_WINDOW_ACC_TLAST_EN
   assign m_tlast = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stimulus table, observed outputs and model offers, one slot per cycle.
   logic         in_v [MAXC];
   logic [W-1:0] in_d [MAXC];
   logic [C-1:0] in_c [MAXC];
   logic         in_r [MAXC];
   logic         in_l [MAXC];
   logic         obs_v [MAXC];
   logic [W-1:0] obs_d [MAXC];
   logic [C-1:0] obs_u [MAXC];
   logic         obs_l [MAXC];
   logic         off_v [MAXC];
   logic [W-1:0] off_d [MAXC];
   logic [C-1:0] off_u [MAXC];
   logic         off_l [MAXC];
   int           x_cyc [$];
   logic [W-1:0] x_dat [$];
   logic [C-1:0] x_usr [$];
   logic         x_lst [$];
   logic [15:0]  drops_obs;

   function automatic logic [W-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         in_v[c] = 1'b0; in_d[c] = '0; in_c[c] = '0; in_r[c] = 1'b1; in_l[c] = 1'b0;
      end
   endtask

   task automatic apply_reset();
      areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_tlast = 1'b0;
      cfg_len = '0; m_axis_tready = 1'b0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
   endtask

   task automatic run_phase(input string name, input int n);
      int           k, j, e, cnt, drops;
      logic [W-1:0] acc, held_d;
      logic [C-1:0] held_u;
      logic         last, full, held_l;
      apply_reset();
      x_cyc.delete(); x_dat.delete(); x_usr.delete(); x_lst.delete();
      for (int c = 0; c < n; c++) begin
         s_axis_tvalid = in_v[c]; s_axis_tdata = in_d[c]; cfg_len = in_c[c];
         m_axis_tready = in_r[c]; s_tlast = in_l[c];
         @(negedge aclk);
         obs_v[c] = m_axis_tvalid; obs_d[c] = m_axis_tdata;
         obs_u[c] = m_axis_tuser;  obs_l[c] = m_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            x_cyc.push_back(c); x_dat.push_back(m_axis_tdata);
            x_usr.push_back(m_axis_tuser); x_lst.push_back(m_tlast);
            $display("%s xfer cyc=%0d tuser=%0d tlast=%0d tdata=%032h",
                     name, c, m_axis_tuser, m_tlast, m_axis_tdata);
         end
         @(posedge aclk);
         #1;
      end
      s_axis_tvalid = 1'b0; m_axis_tready = 1'b0; s_tlast = 1'b0;
      @(negedge aclk);
      drops_obs = sts_drops;

      // Reference: walk the sample table window by window.
      for (int c = 0; c < n; c++) off_v[c] = 1'b0;
      k = 0;
      while (k < n) begin
         if (!in_v[k]) begin k++; continue; end
         if (in_c[k] == '0) begin
            off_v[k] = 1'b1; off_d[k] = in_d[k]; off_u[k] = 8'd1; off_l[k] = in_l[k];
            k++;
            continue;
         end
         acc = in_d[k]; cnt = 1; last = in_l[k];
         e = k + int'(in_c[k]) - 1;
         j = k;
         while (!last && j < e && j < n - 1) begin
            j++;
            if (in_v[j]) begin
               acc = acc | (in_d[j] & FLAG_MASK);
               if (cnt < 255) cnt++;
               last = in_l[j];
            end
         end
         if (!last && j < e) break;
         off_v[j] = 1'b1; off_d[j] = acc; off_u[j] = C'(cnt); off_l[j] = last;
         k = j + 1;
      end

      // Reference: single-slot output buffer replayed against the ready pattern.
      full = 1'b0; held_d = '0; held_u = '0; held_l = 1'b0; drops = 0;
      for (int c = 0; c < n; c++) begin
         check($sformatf("%s_tvalid[%0d]", name, c), W'(obs_v[c]), W'(full));
         if (full) begin
            check($sformatf("%s_tdata[%0d]", name, c), obs_d[c], held_d);
            check($sformatf("%s_tuser[%0d]", name, c), W'(obs_u[c]), W'(held_u));
`ifdef AXIS_WINDOW_ACC_TLAST_EN
            check($sformatf("%s_tlast[%0d]", name, c), W'(obs_l[c]), W'(held_l));
`endif
         end
         if (off_v[c]) begin
            if (!full || in_r[c]) begin
               full = 1'b1; held_d = off_d[c]; held_u = off_u[c]; held_l = off_l[c];
            end else if (drops < 65535) begin
               drops++;
            end
         end else if (full && in_r[c]) begin
            full = 1'b0;
         end
      end
      check($sformatf("%s_drops", name), W'(drops_obs), W'(drops));
      @(posedge aclk);
      #1;
   endtask

   initial begin
      logic [W-1:0] d_exp, rd0, rd1, rd2, got_d;
      logic [C-1:0] got_u;
      int           seen, lat, vp, rp;
      logic [C-1:0] cur_cfg;
      logic [C-1:0] cfg_tab [7];
      int           ready_pct [4];
      logic         got;

      // Reset state.
      apply_reset();
      @(negedge aclk);
      check("rst_tvalid", W'(m_axis_tvalid), '0);
      check("rst_tdata", m_axis_tdata, '0);
      check("rst_tuser", W'(m_axis_tuser), '0);
      check("rst_drops", W'(sts_drops), '0);

      // Window of 4, three samples, flags OR-merged, upper bits from the first sample.
      clear_stim();
      for (int c = 0; c < 10; c++) in_c[c] = 8'd4;
      in_v[0] = 1'b1; in_d[0] = {8'hAB, 120'h1};
      in_v[1] = 1'b1; in_d[1] = {8'hCD, 120'h4};
      in_v[2] = 1'b1; in_d[2] = {8'hCD, 120'h100};
      d_exp = {8'hAB, 120'h105};
      run_phase("win4", 10);
      check("win4_count", W'(x_cyc.size()), W'(1));
      if (x_cyc.size() > 0) begin
         check("win4_cycle", W'(x_cyc[0]), W'(4));
         check("win4_tdata", x_dat[0], d_exp);
         check("win4_tuser", W'(x_usr[0]), W'(3));
      end

      // Pass-through.
      clear_stim();
      for (int c = 0; c < 3; c++) begin in_v[c] = 1'b1; in_d[c] = rand_word(); end
      run_phase("pass", 8);
      check("pass_count", W'(x_cyc.size()), W'(3));
      for (int i = 0; i < 3 && i < x_cyc.size(); i++) begin
         check($sformatf("pass_cycle%0d", i), W'(x_cyc[i]), W'(i + 1));
         check($sformatf("pass_tdata%0d", i), x_dat[i], in_d[i]);
         check($sformatf("pass_tuser%0d", i), W'(x_usr[i]), W'(1));
      end

      // Back-pressure: first result held, four dropped, then one transfer.
      clear_stim();
      for (int c = 0; c < 16; c++) begin
         in_c[c] = 8'd2; in_r[c] = (c >= 10);
         if (c < 10) begin in_v[c] = 1'b1; in_d[c] = rand_word(); end
      end
      run_phase("stall", 16);
      check("stall_drops4", W'(drops_obs), W'(4));
      check("stall_count", W'(x_cyc.size()), W'(1));
      if (x_cyc.size() > 0) begin
         check("stall_cycle", W'(x_cyc[0]), W'(10));
         check("stall_tuser", W'(x_usr[0]), W'(2));
         check("stall_tdata", x_dat[0], in_d[0] | (in_d[1] & FLAG_MASK));
      end

      // cfg_len changes mid-window: 8-cycle window, then a 3-cycle one.
      clear_stim();
      for (int c = 0; c < 16; c++) begin
         in_c[c] = (c < 4) ? 8'd8 : 8'd3; in_d[c] = rand_word();
      end
      in_v[0] = 1'b1; in_v[2] = 1'b1; in_v[5] = 1'b1; in_v[8] = 1'b1; in_v[9] = 1'b1;
      run_phase("cfgchg", 16);
      check("cfgchg_count", W'(x_cyc.size()), W'(2));
      if (x_cyc.size() > 1) begin
         check("cfgchg_cycle0", W'(x_cyc[0]), W'(8));
         check("cfgchg_tuser0", W'(x_usr[0]), W'(3));
         check("cfgchg_cycle1", W'(x_cyc[1]), W'(11));
         check("cfgchg_tuser1", W'(x_usr[1]), W'(2));
      end

      // Maximum window length with a sample every cycle.
      clear_stim();
      for (int c = 0; c < 300; c++) begin in_v[c] = 1'b1; in_c[c] = 8'd255; in_d[c] = rand_word(); end
      run_phase("maxwin", 300);
      check("maxwin_count", W'(x_cyc.size()), W'(1));
      if (x_cyc.size() > 0) begin
         check("maxwin_cycle", W'(x_cyc[0]), W'(255));
         check("maxwin_tuser", W'(x_usr[0]), W'(255));
      end

      // Randomised phases with varying load, window lengths and back-pressure.
      cfg_tab[0] = 8'd0; cfg_tab[1] = 8'd1; cfg_tab[2] = 8'd2; cfg_tab[3] = 8'd3;
      cfg_tab[4] = 8'd4; cfg_tab[5] = 8'd7; cfg_tab[6] = 8'd13;
      ready_pct[0] = 100; ready_pct[1] = 70; ready_pct[2] = 30; ready_pct[3] = 5;
      for (int p = 0; p < 4; p++) begin
         clear_stim();
         vp = 40 + 15 * p;
         rp = ready_pct[p];
         cur_cfg = cfg_tab[$urandom_range(6)];
         for (int c = 0; c < 400; c++) begin
            if ($urandom_range(15) == 0) cur_cfg = cfg_tab[$urandom_range(6)];
            in_c[c] = cur_cfg;
            in_v[c] = ($urandom_range(99) < vp);
            in_d[c] = rand_word();
            in_r[c] = ($urandom_range(99) < rp);
`ifdef AXIS_WINDOW_ACC_TLAST_EN
            in_l[c] = in_v[c] && ($urandom_range(7) == 0);
`endif
         end
         run_phase($sformatf("rnd%0d", p), 400);
      end

      // Reset in cycle 2 of a 5-cycle window discards it; a fresh window counts from 1.
      apply_reset();
      rd0 = rand_word(); rd1 = rand_word(); rd2 = rand_word();
      m_axis_tready = 1'b1; cfg_len = 8'd5;
      s_axis_tvalid = 1'b1; s_axis_tdata = rd0;
      @(posedge aclk); #1;
      s_axis_tdata = rd1;
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0; areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid) seen++;
         @(posedge aclk); #1;
      end
      check("rstmid_no_output", W'(seen), W'(0));
      check("rstmid_drops", W'(sts_drops), W'(0));
      cfg_len = 8'd2; s_axis_tvalid = 1'b1; s_axis_tdata = rd2;
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
      got = 1'b0; lat = -1; got_d = '0; got_u = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid && !got) begin
            got = 1'b1; lat = i; got_d = m_axis_tdata; got_u = m_axis_tuser;
            $display("rstmid xfer lat=%0d tuser=%0d tdata=%032h", i, m_axis_tuser, m_axis_tdata);
         end
         @(posedge aclk); #1;
      end
      check("rstmid_got_output", W'(got), W'(1));
      check("rstmid_latency", W'(lat), W'(1));
      check("rstmid_tuser", W'(got_u), W'(1));
      check("rstmid_tdata", got_d, rd2);

`ifdef AXIS_WINDOW_ACC_TLAST_EN
      // tlast on the third sample force-closes a 10-cycle window.
      clear_stim();
      for (int c = 0; c < 10; c++) in_c[c] = 8'd10;
      for (int c = 0; c < 3; c++) begin in_v[c] = 1'b1; in_d[c] = rand_word(); end
      in_l[2] = 1'b1;
      run_phase("tlast", 10);
      check("tlast_count", W'(x_cyc.size()), W'(1));
      if (x_cyc.size() > 0) begin
         check("tlast_cycle", W'(x_cyc[0]), W'(3));
         check("tlast_tuser", W'(x_usr[0]), W'(3));
         check("tlast_flag", W'(x_lst[0]), W'(1));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
